alu_station: RTL and testbench

Reservation station that feeds the ALU execution unit of the out-of-order core. It buffers ALU-class instructions from dispatch and snoops the two result broadcast buses (ALU and LSB) to wake up pending operands. Each cycle it issues at most one operand-complete entry to the ALU through the calc_enable/lhs/rhs/op/rob_dep interface. The ALU answers with ready/rob_id/value, which this block also snoops.

---
 rtl/alu_station.sv | 153 +++++++++++++++
 tb/tb_alu_station.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_station.sv
// Reservation station in front of the ALU: buffers dispatched instructions,
// snoops the ALU/LSB result buses for operand wakeup, and issues one ready entry per cycle.
module alu_station #(
    parameter int unsigned RS_SIZE   = 8,
    parameter int unsigned RS_WIDTH  = 3,
    parameter int unsigned ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic                 dec_valid,
    input  logic [8:0]           dec_op,
    input  logic [31:0]          dec_vj,
    input  logic                 dec_qj_busy,
    input  logic [ROB_WIDTH-1:0] dec_qj,
    input  logic [31:0]          dec_vk,
    input  logic                 dec_qk_busy,
    input  logic [ROB_WIDTH-1:0] dec_qk,
    input  logic [ROB_WIDTH-1:0] dec_rob_id,
    output logic                 full,
    input  logic                 alu_ready,
    input  logic [ROB_WIDTH-1:0] alu_rob_id,
    input  logic [31:0]          alu_value,
    input  logic                 lsb_ready,
    input  logic [ROB_WIDTH-1:0] lsb_rob_id,
    input  logic [31:0]          lsb_value,
    output logic                 calc_enable,
    output logic [31:0]          lhs,
    output logic [31:0]          rhs,
    output logic [8:0]           op,
    output logic [ROB_WIDTH-1:0] rob_dep
);

    logic [RS_SIZE-1:0]   busy;
    logic [RS_SIZE-1:0]   qj_busy;
    logic [RS_SIZE-1:0]   qk_busy;
    logic [8:0]           ent_op [RS_SIZE];
    logic [31:0]          vj     [RS_SIZE];
    logic [31:0]          vk     [RS_SIZE];
    logic [ROB_WIDTH-1:0] qj     [RS_SIZE];
    logic [ROB_WIDTH-1:0] qk     [RS_SIZE];
    logic [ROB_WIDTH-1:0] rob_id [RS_SIZE];

    logic [RS_SIZE-1:0]  ready_vec;
    logic                issue_found;
    logic [RS_WIDTH-1:0] issue_idx;
    logic [RS_WIDTH-1:0] free_idx;
    logic [31:0]         byp_vj;
    logic [31:0]         byp_vk;
    logic                byp_qj_busy;
    logic                byp_qk_busy;

    assign full      = &busy;
    assign ready_vec = busy & ~qj_busy & ~qk_busy;

    // Descending scan so the lowest index is the last (winning) assignment.
    always_comb begin
        issue_found = |ready_vec;
        issue_idx   = '0;
        free_idx    = '0;
        for (int unsigned i = RS_SIZE; i > 0; i--) begin
            if (ready_vec[RS_WIDTH'(i - 1)]) issue_idx = RS_WIDTH'(i - 1);
            if (!busy[RS_WIDTH'(i - 1)])     free_idx  = RS_WIDTH'(i - 1);
        end
    end

    // Same-cycle broadcast forwarding into the dispatched operands.
    always_comb begin
        byp_vj      = dec_vj;
        byp_qj_busy = dec_qj_busy;
        byp_vk      = dec_vk;
        byp_qk_busy = dec_qk_busy;
        if (dec_qj_busy) begin
            if (alu_ready && alu_rob_id == dec_qj) begin
                byp_vj      = alu_value;
                byp_qj_busy = 1'b0;
            end else if (lsb_ready && lsb_rob_id == dec_qj) begin
                byp_vj      = lsb_value;
                byp_qj_busy = 1'b0;
            end
        end
        if (dec_qk_busy) begin
            if (alu_ready && alu_rob_id == dec_qk) begin
                byp_vk      = alu_value;
                byp_qk_busy = 1'b0;
            end else if (lsb_ready && lsb_rob_id == dec_qk) begin
                byp_vk      = lsb_value;
                byp_qk_busy = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy        <= '0;
            calc_enable <= 1'b0;
            lhs         <= '0;
            rhs         <= '0;
            op          <= '0;
            rob_dep     <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                busy        <= '0;
                calc_enable <= 1'b0;
            end else begin
                for (int unsigned i = 0; i < RS_SIZE; i++) begin
                    if (busy[RS_WIDTH'(i)] && qj_busy[RS_WIDTH'(i)]) begin
                        if (alu_ready && alu_rob_id == qj[RS_WIDTH'(i)]) begin
                            vj[RS_WIDTH'(i)]      <= alu_value;
                            qj_busy[RS_WIDTH'(i)] <= 1'b0;
                        end else if (lsb_ready && lsb_rob_id == qj[RS_WIDTH'(i)]) begin
                            vj[RS_WIDTH'(i)]      <= lsb_value;
                            qj_busy[RS_WIDTH'(i)] <= 1'b0;
                        end
                    end
                    if (busy[RS_WIDTH'(i)] && qk_busy[RS_WIDTH'(i)]) begin
                        if (alu_ready && alu_rob_id == qk[RS_WIDTH'(i)]) begin
                            vk[RS_WIDTH'(i)]      <= alu_value;
                            qk_busy[RS_WIDTH'(i)] <= 1'b0;
                        end else if (lsb_ready && lsb_rob_id == qk[RS_WIDTH'(i)]) begin
                            vk[RS_WIDTH'(i)]      <= lsb_value;
                            qk_busy[RS_WIDTH'(i)] <= 1'b0;
                        end
                    end
                end
                if (issue_found) begin
                    calc_enable     <= 1'b1;
                    lhs             <= vj[issue_idx];
                    rhs             <= vk[issue_idx];
                    op              <= ent_op[issue_idx];
                    rob_dep         <= rob_id[issue_idx];
                    busy[issue_idx] <= 1'b0;
                end else begin
                    calc_enable <= 1'b0;
                end
                // free_idx comes from pre-edge busy, so it never aliases issue_idx.
                if (dec_valid && !full) begin
                    busy[free_idx]    <= 1'b1;
                    ent_op[free_idx]  <= dec_op;
                    vj[free_idx]      <= byp_vj;
                    qj[free_idx]      <= dec_qj;
                    qj_busy[free_idx] <= byp_qj_busy;
                    vk[free_idx]      <= byp_vk;
                    qk[free_idx]      <= dec_qk;
                    qk_busy[free_idx] <= byp_qk_busy;
                    rob_id[free_idx]  <= dec_rob_id;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_station.sv
// Bench for alu_station: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a behavioural station model.
module tb_alu_station;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, clear, dec_valid;
    logic [8:0]  dec_op;
    logic [31:0] dec_vj, dec_vk;
    logic        dec_qj_busy, dec_qk_busy;
    logic [3:0]  dec_qj, dec_qk, dec_rob_id;
    logic        full;
    logic        alu_ready, lsb_ready;
    logic [3:0]  alu_rob_id, lsb_rob_id;
    logic [31:0] alu_value, lsb_value;
    logic        calc_enable;
    logic [31:0] lhs, rhs;
    logic [8:0]  op;
    logic [3:0]  rob_dep;

    always #5 clk = ~clk;

    alu_station #(.RS_SIZE(8), .RS_WIDTH(3), .ROB_WIDTH(4)) dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .dec_valid(dec_valid), .dec_op(dec_op), .dec_vj(dec_vj),
        .dec_qj_busy(dec_qj_busy), .dec_qj(dec_qj), .dec_vk(dec_vk),
        .dec_qk_busy(dec_qk_busy), .dec_qk(dec_qk), .dec_rob_id(dec_rob_id),
        .full(full), .alu_ready(alu_ready), .alu_rob_id(alu_rob_id),
        .alu_value(alu_value), .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id),
        .lsb_value(lsb_value), .calc_enable(calc_enable), .lhs(lhs), .rhs(rhs),
        .op(op), .rob_dep(rob_dep)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a bag of waiting instructions plus the ALU-side output latch.
    typedef struct {
        bit          busy;
        logic [8:0]  op;
        logic [31:0] vj, vk;
        logic [3:0]  qj, qk;
        bit          wj, wk;
        logic [3:0]  rob;
    } ent_t;

    ent_t        m[8];
    bit          m_ce = 1'b0;
    logic [31:0] m_lhs = '0, m_rhs = '0;
    logic [8:0]  m_op = '0;
    logic [3:0]  m_dep = '0;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 8; i++) if (m[i].busy) n++;
        return n;
    endfunction

    function automatic void snoop(inout bit w, inout logic [31:0] v, input logic [3:0] q);
        if (w) begin
            if (alu_ready && alu_rob_id == q) begin
                v = alu_value; w = 1'b0;
            end else if (lsb_ready && lsb_rob_id == q) begin
                v = lsb_value; w = 1'b0;
            end
        end
    endfunction

    function automatic void model_edge();
        ent_t nxt[8];
        int   iss = -1;
        int   f   = -1;
        if (rst_in) begin
            for (int i = 0; i < 8; i++) m[i].busy = 1'b0;
            m_ce = 1'b0; m_lhs = '0; m_rhs = '0; m_op = '0; m_dep = '0;
            return;
        end
        if (!rdy_in) return;
        if (clear) begin
            for (int i = 0; i < 8; i++) m[i].busy = 1'b0;
            m_ce = 1'b0;
            return;
        end
        nxt = m;
        for (int i = 0; i < 8; i++)
            if (iss < 0 && m[i].busy && !m[i].wj && !m[i].wk) iss = i;
        for (int i = 0; i < 8; i++) begin
            if (nxt[i].busy) begin
                snoop(nxt[i].wj, nxt[i].vj, nxt[i].qj);
                snoop(nxt[i].wk, nxt[i].vk, nxt[i].qk);
            end
        end
        if (iss >= 0) begin
            m_ce = 1'b1; m_lhs = m[iss].vj; m_rhs = m[iss].vk;
            m_op = m[iss].op; m_dep = m[iss].rob;
            nxt[iss].busy = 1'b0;
        end else begin
            m_ce = 1'b0;
        end
        if (dec_valid && m_count() < 8) begin
            for (int i = 0; i < 8; i++) if (f < 0 && !m[i].busy) f = i;
            nxt[f] = '{1'b1, dec_op, dec_vj, dec_vk, dec_qj, dec_qk,
                       dec_qj_busy, dec_qk_busy, dec_rob_id};
            snoop(nxt[f].wj, nxt[f].vj, nxt[f].qj);
            snoop(nxt[f].wk, nxt[f].vk, nxt[f].qk);
        end
        m = nxt;
    endfunction

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        chk("m_calc_enable", 32'(calc_enable), 32'(m_ce));
        chk("m_lhs", lhs, m_lhs);
        chk("m_rhs", rhs, m_rhs);
        chk("m_op", 32'(op), 32'(m_op));
        chk("m_rob_dep", 32'(rob_dep), 32'(m_dep));
        chk("m_full", 32'(full), 32'(m_count() == 8));
    endtask

    task automatic idle();
        rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; dec_valid = 1'b0;
        dec_op = '0; dec_vj = '0; dec_vk = '0; dec_qj_busy = 1'b0; dec_qk_busy = 1'b0;
        dec_qj = '0; dec_qk = '0; dec_rob_id = '0;
        alu_ready = 1'b0; alu_rob_id = '0; alu_value = '0;
        lsb_ready = 1'b0; lsb_rob_id = '0; lsb_value = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1'b1;
        cyc();
        rst_in = 1'b0;
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_calc_enable", 32'(calc_enable), 32'd0);
    endtask

    task automatic dispatch(input logic [8:0] o, input logic [31:0] vj, input logic qjb,
                            input logic [3:0] qj, input logic [31:0] vk, input logic [3:0] rob);
        dec_valid = 1'b1; dec_op = o; dec_vj = vj; dec_qj_busy = qjb; dec_qj = qj;
        dec_vk = vk; dec_qk_busy = 1'b0; dec_qk = '0; dec_rob_id = rob;
    endtask

    typedef struct {
        logic [8:0]  op;
        logic [31:0] vj, vk;
        logic        qjb;
        logic [3:0]  qj, rob;
        logic        ar;
        logic [3:0]  at;
        logic [31:0] av;
        logic        lr;
        logic [3:0]  lt;
        logic [31:0] lv;
        logic        exp_issue;
        logic [31:0] exp_lhs;
    } vec_t;

    localparam logic [8:0] ADD = 9'h001;
    localparam logic [8:0] SUB = 9'h002;

    initial begin
        vec_t tbl[5];
        tbl[0] = '{ADD, 32'd5, 32'd7, 1'b0, 4'd0, 4'd3, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 32'd5};
        tbl[1] = '{ADD, 32'h1234, 32'd2, 1'b1, 4'd4, 4'd5, 1'b1, 4'd4, 32'h55, 1'b0, 4'd0, 32'd0, 1'b1, 32'h55};
        tbl[2] = '{SUB, 32'h0, 32'd9, 1'b1, 4'd7, 4'd6, 1'b0, 4'd0, 32'd0, 1'b1, 4'd7, 32'hABCD, 1'b1, 32'hABCD};
        tbl[3] = '{ADD, 32'h0, 32'd1, 1'b1, 4'd2, 4'd8, 1'b1, 4'd2, 32'h11, 1'b1, 4'd2, 32'h22, 1'b1, 32'h11};
        tbl[4] = '{ADD, 32'h0, 32'd1, 1'b1, 4'd9, 4'd10, 1'b1, 4'd8, 32'h99, 1'b1, 4'd3, 32'h33, 1'b0, 32'h0};

        do_reset();
        for (int v = 0; v < 5; v++) begin
            idle();
            dispatch(tbl[v].op, tbl[v].vj, tbl[v].qjb, tbl[v].qj, tbl[v].vk, tbl[v].rob);
            alu_ready = tbl[v].ar; alu_rob_id = tbl[v].at; alu_value = tbl[v].av;
            lsb_ready = tbl[v].lr; lsb_rob_id = tbl[v].lt; lsb_value = tbl[v].lv;
            cyc();
            chk("tbl_no_early_issue", 32'(calc_enable), 32'd0);
            idle();
            cyc();
            chk("tbl_issue", 32'(calc_enable), 32'(tbl[v].exp_issue));
            if (tbl[v].exp_issue) begin
                chk("tbl_lhs", lhs, tbl[v].exp_lhs);
                chk("tbl_rhs", rhs, tbl[v].vk);
                chk("tbl_op", 32'(op), 32'(tbl[v].op));
                chk("tbl_rob_dep", 32'(rob_dep), 32'(tbl[v].rob));
            end
            cyc();
        end

        // SUB waiting on a load result
        do_reset();
        dispatch(SUB, 32'd0, 1'b1, 4'd2, 32'd1, 4'd1);
        cyc();
        idle();
        cyc(); chk("sub_wait1", 32'(calc_enable), 32'd0);
        lsb_ready = 1'b1; lsb_rob_id = 4'd2; lsb_value = 32'd10;
        cyc(); chk("sub_wait2", 32'(calc_enable), 32'd0);
        idle();
        cyc();
        chk("sub_issue", 32'(calc_enable), 32'd1);
        chk("sub_lhs", lhs, 32'd10);
        chk("sub_rhs", rhs, 32'd1);

        // Fill all entries on tag 6, overflow dispatch, then drain in index order
        do_reset();
        for (int k = 0; k < 8; k++) begin
            dispatch(ADD, 32'd0, 1'b1, 4'd6, 32'(k * 3), 4'(k));
            cyc();
        end
        chk("fill_full", 32'(full), 32'd1);
        dispatch(ADD, 32'hDEAD, 1'b0, 4'd0, 32'd1, 4'd15);
        cyc();
        chk("fill_ignore_full", 32'(full), 32'd1);
        idle();
        alu_ready = 1'b1; alu_rob_id = 4'd6; alu_value = 32'h600;
        cyc();
        chk("fill_wake_no_issue", 32'(calc_enable), 32'd0);
        idle();
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("drain_ce", 32'(calc_enable), 32'd1);
            chk("drain_rob_dep", 32'(rob_dep), 32'(k));
            chk("drain_lhs", lhs, 32'h600);
            chk("drain_rhs", rhs, 32'(k * 3));
            if (k == 0) chk("drain_full_drop", 32'(full), 32'd0);
        end
        cyc();
        chk("drain_done", 32'(calc_enable), 32'd0);

        // Clear with busy entries and a pending issue; same-cycle dispatch dropped
        do_reset();
        dispatch(ADD, 32'd0, 1'b1, 4'd9, 32'd1, 4'd1); cyc();
        dispatch(ADD, 32'd0, 1'b1, 4'd9, 32'd2, 4'd2); cyc();
        dispatch(ADD, 32'd4, 1'b0, 4'd0, 32'd3, 4'd3); cyc();
        dispatch(ADD, 32'd8, 1'b0, 4'd0, 32'd8, 4'd4);
        clear = 1'b1;
        cyc();
        chk("clr_ce", 32'(calc_enable), 32'd0);
        chk("clr_full", 32'(full), 32'd0);
        idle();
        alu_ready = 1'b1; alu_rob_id = 4'd9; alu_value = 32'h9;
        cyc();
        idle();
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("clr_no_issue", 32'(calc_enable), 32'd0);
        end

        // rdy_in low freezes the station
        do_reset();
        dispatch(ADD, 32'd0, 1'b1, 4'd5, 32'd2, 4'd7); cyc();
        dispatch(ADD, 32'd3, 1'b0, 4'd0, 32'd4, 4'd8); cyc();
        idle();
        rdy_in = 1'b0;
        alu_ready = 1'b1; alu_rob_id = 4'd5; alu_value = 32'h77;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall_ce", 32'(calc_enable), 32'd0);
        end
        idle();
        cyc();
        chk("resume_ce", 32'(calc_enable), 32'd1);
        chk("resume_rob", 32'(rob_dep), 32'd8);
        cyc();
        chk("resume_no_capture", 32'(calc_enable), 32'd0);
        alu_ready = 1'b1; alu_rob_id = 4'd5; alu_value = 32'h77;
        cyc();
        idle();
        cyc();
        chk("resume_wake_ce", 32'(calc_enable), 32'd1);
        chk("resume_wake_lhs", lhs, 32'h77);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst_in      = ($urandom_range(0, 299) == 0);
            rdy_in      = ($urandom_range(0, 7) != 0);
            clear       = ($urandom_range(0, 59) == 0);
            dec_valid   = ($urandom_range(0, 1) == 1) && (m_count() < 8);
            dec_op      = 9'($urandom);
            dec_vj      = $urandom;
            dec_vk      = $urandom;
            dec_qj_busy = $urandom_range(0, 1) == 1;
            dec_qk_busy = $urandom_range(0, 2) == 0;
            dec_qj      = 4'($urandom_range(0, 7));
            dec_qk      = 4'($urandom_range(0, 7));
            dec_rob_id  = 4'($urandom);
            alu_ready   = $urandom_range(0, 2) == 0;
            alu_rob_id  = 4'($urandom_range(0, 7));
            alu_value   = $urandom;
            lsb_ready   = $urandom_range(0, 2) == 0;
            lsb_rob_id  = 4'($urandom_range(0, 7));
            lsb_value   = $urandom;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
